conv_frame_encoder: RTL and testbench
=====================================

CONV_FRAME_ENCODER -- requirements
Module: conv_frame_encoder

Interface
REQ-001 Parameter ERR_PERIOD_LOG2, default 4: error-injection period exponent; one symbol in every 2**ERR_PERIOD_LOG2 is corrupted (used only under ENC_ERR_INJ_EN).
REQ-002 Parameter ERR_MASK, default 2'b01: XOR mask applied to a corrupted symbol (used only under ENC_ERR_INJ_EN).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  a byte is offered on in_data.
REQ-006 in_ready  output  1  the encoder accepts the offered byte this cycle.
REQ-007 in_data  input  8  payload byte, serialized MSB first.
REQ-008 in_last  input  1  the offered byte is the final byte of the frame.
REQ-009 out_valid  output  1  out_sym holds a valid code symbol.
REQ-010 out_ready  input  1  the downstream decoder or channel takes the symbol this cycle.
REQ-011 out_sym  output  2  code symbol; [1] = generator 7 (octal), [0] = generator 5 (octal).
REQ-012 out_last  output  1  the final symbol (second tail symbol) of the frame.
REQ-013 busy  output  1  a frame is in progress (state is not IDLE).

Function
REQ-014 The encoder SHALL be a rate-1/2, K=3 convolutional encoder: out_sym[1]=u^s1^s2, out_sym[0]=u^s2, where s1 is the previous input bit and s2 is the bit before it.
REQ-015 The FSM SHALL have three states: IDLE -> DATA on in_valid&&in_ready; DATA -> TAIL after bit 0 of a byte flagged last is taken; TAIL -> IDLE after the second tail symbol is taken.
REQ-016 A symbol SHALL be taken on a cycle with out_valid&&out_ready; out_sym, out_valid and out_last SHALL hold stable while out_valid&&!out_ready.
REQ-017 in_ready SHALL be 1 in IDLE and in DATA when the bit-0 symbol of a non-last byte is being taken; it SHALL be 0 otherwise, giving gapless back-to-back bytes.
REQ-018 Latency: a byte accepted at edge N SHALL present its first symbol (bit 7) with out_valid=1 from cycle N+1.
REQ-019 The bit index SHALL count 7 down to 0 and advance only when a symbol is taken; it SHALL reload to 7 when a new byte is accepted.
REQ-020 In TAIL the encoder SHALL emit two symbols with u=0 to flush s1/s2 to zero, and out_last SHALL be 1 only on the second.
REQ-021 The encoder SHALL clear s1 and s2 on entry to DATA from IDLE, so every frame starts in trellis state 00.
REQ-022 in_data and in_last SHALL be ignored unless in_valid&&in_ready.
REQ-023 out_valid SHALL be 0 in IDLE; busy SHALL drop in the cycle after the last symbol is taken.

Reset
REQ-024 On rst low the encoder SHALL immediately force state=IDLE, s1=s2=0, bit index=7, and the symbol counter to 0.
REQ-025 On rst low the outputs SHALL be out_valid=0, out_sym=00, out_last=0, busy=0 and in_ready=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without emitting a tail.

Configuration
REQ-027 With ENC_ERR_INJ_EN defined, a per-frame symbol counter SHALL increment on each symbol taken.
REQ-028 With ENC_ERR_INJ_EN defined, a symbol SHALL be XORed with ERR_MASK when counter < 256 and counter[ERR_PERIOD_LOG2-1:0] is all ones.
REQ-029 With ENC_ERR_INJ_EN defined, the counter SHALL saturate at 256 and clear at frame start.
REQ-030 Without ENC_ERR_INJ_EN, the counter and the XOR SHALL be absent and out_sym SHALL be the clean encoder output.

Structure
REQ-031 Package conv_pkg SHALL hold the constraint length K=3, the generator constants G1=3'b111 and G0=3'b101, and the state enum typedef (IDLE, DATA, TAIL).
REQ-032 The generator arithmetic SHALL be a sub-module conv_sym_gen (inputs u, s1, s2; output sym[1:0]), shared with the decoder's branch-metric logic.

Verification
REQ-033 One byte 0x80 with in_last=1, out_ready=1 -> 10 symbols 11,10,11,00,00,00,00,00,00,00; out_last only on the 10th.
REQ-034 One byte 0xFF with in_last=1 -> symbols 11,01,10,10,10,10,10,10,01,11; busy falls one cycle after the last symbol.
REQ-035 Two bytes 0x80 then 0x00 (last), in_valid held high -> in_ready pulses on the bit-0 symbol of byte 1 only, no bubble between bytes, 18 symbols total.
REQ-036 out_ready toggled pseudo-randomly -> the symbol stream is identical to the out_ready=1 stream, and out_sym never changes while stalled.
REQ-037 rst pulsed low after the 4th symbol of a frame -> out_valid=0 immediately; the next frame 0x80 reproduces REQ-033 exactly.
REQ-038 ENC_ERR_INJ_EN with defaults, 40-byte frame of 0x00 -> only symbols 15, 31, ..., 255 read 01; all other symbols read 00.

Source files
------------

// File: rtl/conv_frame_encoder_pkg.sv
// Shared constants and types for the K=3, rate-1/2 convolutional frame encoder.
package conv_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

endpackage

// File: rtl/conv_frame_encoder_if.sv
// Byte-in / symbol-out handshake bundle of the convolutional frame encoder.
interface conv_frame_encoder_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_last;

    // master is the frame source / symbol sink, slave is the encoder
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );

endinterface

// File: rtl/conv_frame_encoder_sym_gen.sv
// Generator arithmetic for one code symbol; also reused by the decoder branch metrics.
module conv_sym_gen
    import conv_pkg::*;
(
    input  logic       u,
    input  logic       s1,
    input  logic       s2,
    output logic [1:0] sym
);

    logic [K-1:0] taps;

    assign taps = {u, s1, s2};
    assign sym  = {^(G1 & taps), ^(G0 & taps)};

endmodule

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 K=3 frame encoder: bytes in MSB first, two flush symbols per frame.
// Optional periodic symbol corruption is compiled in with `define ENC_ERR_INJ_EN.
module conv_frame_encoder
    import conv_pkg::*;
#(
    parameter int         ERR_PERIOD_LOG2 = 4,
    parameter logic [1:0] ERR_MASK        = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_frame_encoder_if.slave  enc,
    output logic                 busy
);

    state_t     state, state_nxt;
    logic [7:0] data_q;
    logic       last_q;
    logic       have_q;
    logic [2:0] bit_idx;
    logic       tail_idx;
    logic       s1, s2;
    logic       u;
    logic [1:0] clean_sym;
    logic       taken;
    logic       byte_end;
    logic       accept;

    assign u         = (state == DATA) ? data_q[bit_idx] : 1'b0;
    assign taken     = enc.out_valid && enc.out_ready;
    assign byte_end  = (state == DATA) && taken && (bit_idx == 3'd0);
    assign accept    = enc.in_valid && enc.in_ready;
    assign busy      = (state != IDLE);

    // A DATA state without a loaded byte only arises if the source starves mid-frame
    assign enc.out_valid = (state == TAIL) || ((state == DATA) && have_q);
    assign enc.in_ready  = (state == IDLE) || ((state == DATA) && !have_q) ||
                           (byte_end && !last_q);
    assign enc.out_last  = (state == TAIL) && tail_idx;

    conv_sym_gen u_sym_gen (
        .u   (u),
        .s1  (s1),
        .s2  (s2),
        .sym (clean_sym)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = DATA;
            DATA: if (byte_end && last_q) state_nxt = TAIL;
            TAIL: if (taken && tail_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            bit_idx  <= 3'd7;
            tail_idx <= 1'b0;
            data_q   <= 8'd0;
            last_q   <= 1'b0;
            have_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else if (taken) begin
                s2 <= s1;
                s1 <= u;
            end
            if (accept) begin
                data_q  <= enc.in_data;
                last_q  <= enc.in_last;
                bit_idx <= 3'd7;
                have_q  <= 1'b1;
            end else if (state == DATA && taken) begin
                bit_idx <= bit_idx - 3'd1;
                if (bit_idx == 3'd0) have_q <= 1'b0;
            end
            if (state == TAIL && taken) tail_idx <= ~tail_idx;
        end
    end

`ifdef ENC_ERR_INJ_EN
    logic [8:0] sym_cnt;
    logic       inject;

    // Saturates at 256 so injection stops after the first 256 symbols of a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt <= 9'd0;
        end else if (state == IDLE && accept) begin
            sym_cnt <= 9'd0;
        end else if (taken && !sym_cnt[8]) begin
            sym_cnt <= sym_cnt + 9'd1;
        end
    end

    assign inject      = !sym_cnt[8] && (&sym_cnt[ERR_PERIOD_LOG2-1:0]);
    assign enc.out_sym = inject ? (clean_sym ^ ERR_MASK) : clean_sym;
`else
    assign enc.out_sym = clean_sym;
`endif

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Bench for conv_frame_encoder: vector table plus symbol scoreboard.
module tb_conv_frame_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    conv_frame_encoder_if bus ();

    conv_frame_encoder #(
        .ERR_PERIOD_LOG2 (4),
        .ERR_MASK        (2'b01)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .enc  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [19:0] syms;
    } vec_t;

    vec_t       vecs [5];
    logic [2:0] exp_q [$];
    logic [7:0] tx_q  [$];
    int         total = 0;
    int         bad   = 0;
    bit         rnd_mode = 1'b0;
    int         ntaken = 0;
    int         busy_cycles = 0;
    int         inrdy_busy = 0;
    int         bubbles = 0;

    task automatic check(input string name, input logic ok, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: bit-serial convolution plus two flush symbols per frame
    task automatic push_model();
        logic       ms1, ms2, mu;
        logic [1:0] sym;
        int         n;
        ms1 = 1'b0;
        ms2 = 1'b0;
        n   = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                mu  = tx_q[i][b];
                sym = {mu ^ ms1 ^ ms2, mu ^ ms2};
`ifdef ENC_ERR_INJ_EN
                if (n < 256 && (n % 16) == 15) sym = sym ^ 2'b01;
`endif
                exp_q.push_back({1'b0, sym});
                ms2 = ms1;
                ms1 = mu;
                n++;
            end
        end
        for (int t = 0; t < 2; t++) begin
            sym = {ms1 ^ ms2, ms2};
`ifdef ENC_ERR_INJ_EN
            if (n < 256 && (n % 16) == 15) sym = sym ^ 2'b01;
`endif
            exp_q.push_back({(t == 1), sym});
            ms2 = ms1;
            ms1 = 1'b0;
            n++;
        end
    endtask

    task automatic push_vec(input int k);
        logic [19:0] s;
        s = vecs[k].syms;
        for (int j = 0; j < 10; j++) exp_q.push_back({(j == 9), s[19-2*j -: 2]});
    endtask

    task automatic send_frame();
        int guard;
        for (int i = 0; i < tx_q.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tx_q[i];
            bus.in_last  = (i == tx_q.size() - 1);
            guard = 0;
            @(negedge clk);
            while (!bus.in_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.in_ready) check("accept_timeout", 1'b0, 0, 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || busy) check("drain_timeout", 1'b0, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int k);
        push_vec(k);
        tx_q = {vecs[k].data};
        send_frame();
        check("latency", bus.out_valid == 1'b1, bus.out_valid, 1);
        wait_idle();
    endtask

    // Symbol monitor: taken symbols, stall stability, busy release
    logic       prev_stall = 1'b0;
    logic [1:0] prev_sym = 2'b00;
    logic       prev_lastv = 1'b0;
    logic       prev_last_taken = 1'b0;
    logic [2:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall      = 1'b0;
            prev_last_taken = 1'b0;
        end else begin
            if (prev_last_taken) check("busy_fall", busy == 1'b0, busy, 0);
            if (prev_stall)
                check("stall_hold", bus.out_valid && bus.out_sym == prev_sym &&
                      bus.out_last == prev_lastv, {bus.out_valid, bus.out_last, bus.out_sym},
                      {1'b1, prev_lastv, prev_sym});
            if (bus.out_valid && bus.out_ready) begin
                ntaken++;
                if (exp_q.size() == 0) begin
                    check("extra_symbol", 1'b0, bus.out_sym, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("symbol", {bus.out_last, bus.out_sym} == e,
                          {bus.out_last, bus.out_sym}, e);
                end
            end
            if (busy) busy_cycles++;
            if (busy && bus.in_ready) inrdy_busy++;
            if (busy && !bus.out_valid) bubbles++;
            prev_stall      = bus.out_valid && !bus.out_ready;
            prev_sym        = bus.out_sym;
            prev_lastv      = bus.out_last;
            prev_last_taken = bus.out_valid && bus.out_ready && bus.out_last;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{8'h80, 20'b11_10_11_00_00_00_00_00_00_00};
        vecs[1] = '{8'hFF, 20'b11_01_10_10_10_10_10_10_01_11};
        vecs[2] = '{8'h00, 20'b00_00_00_00_00_00_00_00_00_00};
        vecs[3] = '{8'h01, 20'b00_00_00_00_00_00_00_11_10_11};
        vecs[4] = '{8'hA0, 20'b11_10_00_10_11_00_00_00_00_00};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        check("rst_out_sym", bus.out_sym == 2'b00, bus.out_sym, 0);
        check("rst_out_last", bus.out_last == 1'b0, bus.out_last, 0);
        check("rst_busy", busy == 1'b0, busy, 0);
        check("rst_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) run_vec(k);
        rnd_mode = 1'b1;
        for (int k = 0; k < 5; k++) run_vec(k);
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;

        // Two back-to-back bytes with in_valid held high
        busy_cycles = 0;
        inrdy_busy  = 0;
        bubbles     = 0;
        base        = ntaken;
        tx_q = {8'h80, 8'h00};
        push_model();
        send_frame();
        wait_idle();
        check("b2b_symbols", ntaken - base == 18, ntaken - base, 18);
        check("b2b_busy_cycles", busy_cycles == 18, busy_cycles, 18);
        check("b2b_in_ready_pulses", inrdy_busy == 1, inrdy_busy, 1);
        check("b2b_bubbles", bubbles == 0, bubbles, 0);

        // Random stalls over a multi-byte frame
        rnd_mode = 1'b1;
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
        push_model();
        send_frame();
        wait_idle();
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;

        // Long all-zero frame exercises the injection window when enabled
        tx_q.delete();
        for (int i = 0; i < 40; i++) tx_q.push_back(8'h00);
        push_model();
        send_frame();
        wait_idle();

        // Reset after the 4th symbol abandons the frame
        base = ntaken;
        push_vec(0);
        tx_q = {8'h80};
        send_frame();
        begin
            int guard;
            guard = 0;
            while (ntaken < base + 4 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (ntaken < base + 4) check("reset_wait_timeout", 1'b0, ntaken - base, 4);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        check("midrst_busy", busy == 1'b0, busy, 0);
        check("midrst_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
        check("midrst_out_sym", bus.out_sym == 2'b00, bus.out_sym, 0);
        check("midrst_out_last", bus.out_last == 1'b0, bus.out_last, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_vec(0);

        check("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
